// File: rtl/shift_sub_div.sv
// shift_sub_div: sequential restoring (shift-and-subtract) unsigned divider.
// One quotient bit is produced per clock. A division is started by
// opcode 2'b10 while idle. A zero divisor short-circuits straight to
// completion with an all-ones quotient and the dividend as the remainder.
//
// Ports
//   clk          rising-edge clock
//   resetn       asynchronous active-low reset
//   dividend     BW-bit unsigned dividend, sampled on an accepted start
//   divisor      BW-bit unsigned divisor, sampled on an accepted start
//   opcode       2'b10 starts a divide; every other code is ignored
//   quotient     registered quotient, held until the next completion
//   remainder    registered remainder, held until the next completion
//   valid        one-cycle pulse when quotient/remainder/div_by_zero update
//   busy         high while iterating
//   div_by_zero  set with valid when the captured divisor was zero
module shift_sub_div #(
    parameter int BW = 4
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [BW-1:0] dividend,
    input  logic [BW-1:0] divisor,
    input  logic [1:0]    opcode,
    output logic [BW-1:0] quotient,
    output logic [BW-1:0] remainder,
    output logic          valid,
    output logic          busy,
    output logic          div_by_zero
);

    localparam int            CW       = $clog2(BW);
    localparam logic [CW-1:0] LAST_CNT = CW'(BW - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [BW-1:0] d_reg;
    logic [BW-1:0] q_reg;
    logic [BW-1:0] a_reg;
    logic [CW-1:0] count;

    logic          start;
    logic [BW:0]   trial;
    logic [BW:0]   diff;
    logic          no_borrow;
    logic [BW-1:0] a_next;
    logic [BW-1:0] q_next;

    // One restoring step: shift the next dividend bit into the partial
    // remainder, try subtracting the divisor, keep the result only when the
    // extra top bit shows no borrow.
    always_comb begin
        start     = (opcode == 2'b10);
        trial     = {a_reg, q_reg[BW-1]};
        diff      = trial - {1'b0, d_reg};
        no_borrow = ~diff[BW];
        a_next    = no_borrow ? diff[BW-1:0] : trial[BW-1:0];
        q_next    = {q_reg[BW-2:0], no_borrow};
    end

    // valid and busy are registered alongside the state so they track
    // DONE and ITER exactly.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            d_reg       <= '0;
            q_reg       <= '0;
            a_reg       <= '0;
            count       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            valid       <= 1'b0;
            busy        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    valid <= 1'b0;
                    if (start) begin
                        if (divisor != '0) begin
                            d_reg <= divisor;
                            q_reg <= dividend;
                            a_reg <= '0;
                            count <= LAST_CNT;
                            busy  <= 1'b1;
                            state <= ITER;
                        end else begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            valid       <= 1'b1;
                            state       <= DONE;
                        end
                    end
                end
                ITER: begin
                    a_reg <= a_next;
                    q_reg <= q_next;
                    count <= count - CW'(1);
                    if (count == '0) begin
                        quotient    <= q_next;
                        remainder   <= a_next;
                        div_by_zero <= 1'b0;
                        busy        <= 1'b0;
                        valid       <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    valid <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    valid <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sub_div.sv
// tb_shift_sub_div: directed and random checks of shift_sub_div at BW=4
// and BW=8 against a division reference held in a scoreboard queue.
module tb_shift_sub_div;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
        int         lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;

    logic [3:0] dvd4 = '0, dvs4 = '0, q4, r4;
    logic [1:0] op4 = 2'b00;
    logic       v4, b4, z4;

    logic [7:0] dvd8 = '0, dvs8 = '0, q8, r8;
    logic [1:0] op8 = 2'b00;
    logic       v8, b8, z8;

    int checks = 0;
    int errors = 0;
    int valid_cnt4 = 0;
    int valid_cnt8 = 0;
    int accepted4 = 0;
    int accepted8 = 0;
    logic [7:0] last_q [2];
    logic [7:0] last_r [2];
    exp_t sb [$];

    shift_sub_div #(.BW(4)) dut4 (
        .clk(clk), .resetn(resetn), .dividend(dvd4), .divisor(dvs4), .opcode(op4),
        .quotient(q4), .remainder(r4), .valid(v4), .busy(b4), .div_by_zero(z4)
    );

    shift_sub_div #(.BW(8)) dut8 (
        .clk(clk), .resetn(resetn), .dividend(dvd8), .divisor(dvs8), .opcode(op8),
        .quotient(q8), .remainder(r8), .valid(v8), .busy(b8), .div_by_zero(z8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (v4) valid_cnt4++;
        if (v8) valid_cnt8++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] idle_op();
        int unsigned t;
        t = $urandom_range(0, 2);
        return (t == 2) ? 2'b11 : 2'(t);
    endfunction

    // Drive both DUTs' non-start inputs with noise so the captured operands
    // are the only ones that can matter.
    task automatic scramble();
        op4  = idle_op();
        op8  = idle_op();
        dvd4 = 4'($urandom);
        dvs4 = 4'($urandom);
        dvd8 = 8'($urandom);
        dvs8 = 8'($urandom);
    endtask

    // Start a divide on the DUT of width w, then watch it to completion.
    // inj >= 0 issues a second start (7/2) at that cycle, which must be ignored.
    task automatic run_div(input string lbl, input int w, input logic [7:0] a,
                           input logic [7:0] b, input int inj);
        exp_t e;
        exp_t got;
        int   n;
        int   busy_cnt;
        int   idx;
        logic vv, bb, zz;
        logic [7:0] qq, rr;
        logic [7:0] mask;
        idx  = (w == 8) ? 1 : 0;
        mask = (w == 8) ? 8'hFF : 8'h0F;
        if (b == 8'd0) begin
            e.q = mask; e.r = a; e.dbz = 1'b1; e.lat = 0;
        end else begin
            e.q = a / b; e.r = a % b; e.dbz = 1'b0; e.lat = w;
        end
        sb.push_back(e);

        @(negedge clk);
        scramble();
        if (w == 8) begin
            dvd8 = a; dvs8 = b; op8 = 2'b10; accepted8++;
        end else begin
            dvd4 = a[3:0]; dvs4 = b[3:0]; op4 = 2'b10; accepted4++;
        end
        @(negedge clk);
        n = 0;
        busy_cnt = 0;
        vv = 1'b0;
        while (n < 40) begin
            vv = (w == 8) ? v8 : v4;
            bb = (w == 8) ? b8 : b4;
            qq = (w == 8) ? q8 : {4'h0, q4};
            if (vv) break;
            if (bb) busy_cnt++;
            if (n == 1) check($sformatf("%s_hold_q", lbl), qq, last_q[idx]);
            scramble();
            if (n == inj) begin
                if (w == 8) begin dvd8 = 8'd7; dvs8 = 8'd2; op8 = 2'b10; end
                else begin dvd4 = 4'd7; dvs4 = 4'd2; op4 = 2'b10; end
            end
            @(negedge clk);
            n++;
        end
        scramble();
        got = sb.pop_front();
        if (!vv) begin
            check($sformatf("%s_timeout_valid", lbl), vv, 1);
            return;
        end
        qq = (w == 8) ? q8 : {4'h0, q4};
        rr = (w == 8) ? r8 : {4'h0, r4};
        zz = (w == 8) ? z8 : z4;
        check($sformatf("%s_latency", lbl), n, got.lat);
        check($sformatf("%s_busy_cycles", lbl), busy_cnt, got.lat);
        check($sformatf("%s_q", lbl), qq, got.q);
        check($sformatf("%s_r", lbl), rr, got.r);
        check($sformatf("%s_dbz", lbl), zz, got.dbz);
        last_q[idx] = got.q;
        last_r[idx] = got.r;
    endtask

    initial begin
        int vc;
        last_q[0] = '0; last_q[1] = '0;
        last_r[0] = '0; last_r[1] = '0;

        repeat (3) @(negedge clk);
        check("rst_q4", q4, 0);
        check("rst_r4", r4, 0);
        check("rst_valid4", v4, 0);
        check("rst_busy4", b4, 0);
        check("rst_dbz4", z4, 0);
        check("rst_q8", q8, 0);
        resetn = 1'b1;
        @(negedge clk);

        run_div("d13_3", 4, 8'd13, 8'd3, -1);
        run_div("d15_1", 4, 8'd15, 8'd1, -1);
        run_div("d2_7", 4, 8'd2, 8'd7, -1);
        run_div("d15_15", 4, 8'd15, 8'd15, -1);
        run_div("d0_5", 4, 8'd0, 8'd5, -1);
        run_div("d9_0", 4, 8'd9, 8'd0, -1);
        run_div("d8_2", 4, 8'd8, 8'd2, -1);

        // Second start during ITER must be dropped.
        run_div("busy_start", 4, 8'd11, 8'd3, 1);
        repeat (8) @(negedge clk);
        check("busy_start_valids", valid_cnt4, accepted4);
        check("busy_start_q_held", q4, 3);
        check("busy_start_r_held", r4, 2);

        // Reset in the middle of an operation.
        @(negedge clk);
        dvd4 = 4'd13; dvs4 = 4'd5; op4 = 2'b10;
        @(negedge clk);
        op4 = 2'b00;
        @(negedge clk);
        check("midrst_busy_before", b4, 1);
        vc = valid_cnt4;
        #2 resetn = 1'b0;
        #1;
        check("midrst_q", q4, 0);
        check("midrst_r", r4, 0);
        check("midrst_valid", v4, 0);
        check("midrst_busy", b4, 0);
        check("midrst_dbz", z4, 0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (6) @(negedge clk);
        check("midrst_no_valid", valid_cnt4, vc);
        last_q[0] = '0; last_q[1] = '0;
        last_r[0] = '0; last_r[1] = '0;
        run_div("d14_4", 4, 8'd14, 8'd4, -1);

        for (int i = 0; i < 1000; i++)
            run_div("rnd4", 4, {4'h0, 4'($urandom)}, {4'h0, 4'($urandom)}, -1);
        for (int i = 0; i < 1000; i++)
            run_div("rnd8", 8, 8'($urandom), 8'($urandom), -1);

        repeat (4) @(negedge clk);
        check("valid_count4", valid_cnt4, accepted4);
        check("valid_count8", valid_cnt8, accepted8);
        check("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
